gate_accum: RTL and testbench

- Accumulator stage directly downstream of the pipelined signed fixed-point multiplier that feeds the LSTM gate datapath.
- Consumes one full-width product per cycle and sums the products of one weight-row/input dot product, seeded with a per-row bias.
- At end of vector: rounds, rescales and saturates the sum back to dataWidth Q-format, then emits it with a one-cycle valid pulse toward the activation stage.

---
 rtl/gate_accum.sv | 158 +++++++++++++++
 tb/tb_gate_accum.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_accum.sv
`default_nettype none
// ============================================================================
// Module   : gate_accum
// Purpose  : Dot-product accumulator for the LSTM gate datapath. Sums a stream
//            of full-width signed Q(2*FRAC) products, seeded with a per-row
//            Q(FRAC) bias on the first beat. On the last beat it rounds (half
//            up), rescales to Q(FRAC) and saturates to DATA_WIDTH bits. The
//            result is presented with a one-cycle valid pulse.
// Ports    : clk            clock
//            rst            synchronous reset, active-high (overrides ce_i)
//            ce_i           clock enable; 0 freezes every register
//            prod_valid_i   beat present on prod_i
//            prod_last_i    final beat of the vector (qualified by valid)
//            prod_i         signed product, Q(2*FRAC_WIDTH)
//            bias_i         signed bias, Q(FRAC_WIDTH), first beat only
//            sum_out_o      rescaled, saturated result, Q(FRAC_WIDTH)
//            sum_valid_o    one-cycle pulse: sum_out_o is new
//            sat_flag_o     result was clipped (valid with sum_valid_o)
//            beat_count_o   beats in the vector just emitted
//            busy_o         a vector is open
// Revision : 1.0 - initial release
// ============================================================================
module gate_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 14,
  parameter int GUARD_BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce_i,
  input  logic                           prod_valid_i,
  input  logic                           prod_last_i,
  input  logic signed [2*DATA_WIDTH-1:0] prod_i,
  input  logic signed [DATA_WIDTH-1:0]   bias_i,
  output logic signed [DATA_WIDTH-1:0]   sum_out_o,
  output logic                           sum_valid_o,
  output logic                           sat_flag_o,
  output logic [GUARD_BITS:0]            beat_count_o,
  output logic                           busy_o
);

  localparam int c_ACC_W = 2*DATA_WIDTH + GUARD_BITS;
  localparam int c_CNT_W = GUARD_BITS + 1;

  localparam logic signed [c_ACC_W-1:0] c_HALF =
    {{(c_ACC_W-1){1'b0}}, 1'b1} << (FRAC_WIDTH-1);
  localparam logic signed [c_ACC_W-1:0] c_MAX =
    {{(c_ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [c_ACC_W-1:0] c_MIN =
    {{(c_ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] c_OUT_MAX =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] c_OUT_MIN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic signed [c_ACC_W-1:0]     acc_q, acc_d;
  logic [c_CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]  sum_q, sum_d;
  logic                          valid_q, valid_d;
  logic                          sat_q, sat_d;
  logic [c_CNT_W-1:0]            bcount_q, bcount_d;

  logic signed [c_ACC_W-1:0]     w_bias_ext;
  logic signed [c_ACC_W-1:0]     w_seed;
  logic signed [c_ACC_W-1:0]     w_prod_ext;
  logic signed [c_ACC_W-1:0]     w_acc_next;
  logic signed [c_ACC_W-1:0]     w_rounded;
  logic signed [c_ACC_W-1:0]     w_scaled;
  logic [c_CNT_W-1:0]            w_cnt_next;

  // Bias is Q(FRAC); align it to the product's Q(2*FRAC) grid.
  assign w_bias_ext = {{(c_ACC_W-DATA_WIDTH){bias_i[DATA_WIDTH-1]}}, bias_i};
  assign w_seed     = w_bias_ext <<< FRAC_WIDTH;
  assign w_prod_ext = {{(c_ACC_W-2*DATA_WIDTH){prod_i[2*DATA_WIDTH-1]}}, prod_i};

  // The first beat of a vector starts from the bias instead of the old sum,
  // so a new vector may open on the edge right after a last beat.
  assign w_acc_next = ((state_q == ST_IDLE) ? w_seed : acc_q) + w_prod_ext;
  assign w_rounded  = w_acc_next + c_HALF;
  assign w_scaled   = w_rounded >>> FRAC_WIDTH;

  // Beat counter sticks at all-ones on over-long vectors.
  assign w_cnt_next = (state_q == ST_IDLE) ? c_CNT_ONE :
                      (&cnt_q)             ? cnt_q     :
                                             cnt_q + c_CNT_ONE;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    valid_d  = valid_q;
    sat_d    = sat_q;
    bcount_d = bcount_q;

    if (ce_i) begin
      valid_d = 1'b0;
      if (prod_valid_i) begin
        if (prod_last_i) begin
          state_d  = ST_IDLE;
          acc_d    = '0;
          cnt_d    = '0;
          valid_d  = 1'b1;
          bcount_d = w_cnt_next;
          if (w_scaled > c_MAX) begin
            sum_d = c_OUT_MAX;
            sat_d = 1'b1;
          end else if (w_scaled < c_MIN) begin
            sum_d = c_OUT_MIN;
            sat_d = 1'b1;
          end else begin
            sum_d = w_scaled[DATA_WIDTH-1:0];
            sat_d = 1'b0;
          end
        end else begin
          state_d = ST_ACC;
          acc_d   = w_acc_next;
          cnt_d   = w_cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      bcount_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
      bcount_q <= bcount_d;
    end
  end

  assign sum_out_o    = sum_q;
  assign sum_valid_o  = valid_q;
  assign sat_flag_o   = sat_q;
  assign beat_count_o = bcount_q;
  assign busy_o       = (state_q == ST_ACC);

endmodule
`default_nettype wire

// File: tb/tb_gate_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_accum
// Purpose  : Directed self-checking bench for gate_accum (default parameters:
//            16-bit Q14 data, 8 guard bits). Inputs change on the falling
//            edge; outputs are sampled 1 ns after the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_accum;

  logic               clk;
  logic               rst;
  logic               ce;
  logic               prod_valid;
  logic               prod_last;
  logic signed [31:0] prod;
  logic signed [15:0] bias;
  logic signed [15:0] sum_out;
  logic               sum_valid;
  logic               sat_flag;
  logic [8:0]         beat_count;
  logic               busy;

  int checks;
  int errors;

  localparam logic signed [31:0] ONE     = 32'sd268435456;  // 1.0 in Q28
  localparam logic signed [31:0] QUARTER = 32'sd67108864;   // 0.25 in Q28

  gate_accum dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce),
    .prod_valid_i (prod_valid),
    .prod_last_i  (prod_last),
    .prod_i       (prod),
    .bias_i       (bias),
    .sum_out_o    (sum_out),
    .sum_valid_o  (sum_valid),
    .sat_flag_o   (sat_flag),
    .beat_count_o (beat_count),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and advance past the next rising edge.
  task automatic drive(input logic c, input logic v, input logic l,
                       input logic signed [31:0] p, input logic signed [15:0] b);
    @(negedge clk);
    rst        = 1'b0;
    ce         = c;
    prod_valid = v;
    prod_last  = l;
    prod       = p;
    bias       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; ce = 1'b0; prod_valid = 1'b1; prod_last = 1'b1;
    prod = ONE; bias = 16'sd100;
    @(posedge clk);
    #1;
    checks++; if (sum_out !== 16'sd0) begin errors++; $display("FAIL reset_sum_out: got %0d expected 0", sum_out); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid: got %b expected 0", sum_valid); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
    checks++; if (beat_count !== 9'd0) begin errors++; $display("FAIL reset_beat_count: got %0d expected 0", beat_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    drive(1'b1, 1'b1, 1'b1, ONE, 16'sd0);
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", sum_valid); end
    checks++; if (sum_out !== 16'sd16384) begin errors++; $display("FAIL single_out: got %0d expected 16384", sum_out); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL single_sat: got %b expected 0", sat_flag); end
    checks++; if (beat_count !== 9'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", beat_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    drive(1'b1, 1'b0, 1'b0, 32'sd0, 16'sd0);
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_end: got %b expected 0", sum_valid); end
    checks++; if (sum_out !== 16'sd16384) begin errors++; $display("FAIL single_out_hold: got %0d expected 16384", sum_out); end
  endtask

  task automatic test_multi;
    drive(1'b1, 1'b1, 1'b0, QUARTER, 16'sd4096);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multi_busy_b2: got %b expected 1", busy); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL multi_valid_b2: got %b expected 0", sum_valid); end
    // Bias on later beats must be ignored.
    drive(1'b1, 1'b1, 1'b0, QUARTER, 16'sh7fff);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multi_busy_b3: got %b expected 1", busy); end
    drive(1'b1, 1'b1, 1'b1, QUARTER, 16'sh7fff);
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL multi_valid: got %b expected 1", sum_valid); end
    checks++; if (sum_out !== 16'sd16384) begin errors++; $display("FAIL multi_out: got %0d expected 16384", sum_out); end
    checks++; if (beat_count !== 9'd3) begin errors++; $display("FAIL multi_count: got %0d expected 3", beat_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multi_busy_end: got %b expected 0", busy); end
    // A stall holds the pulse.
    drive(1'b0, 1'b1, 1'b1, ONE, 16'sd0);
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL multi_valid_stall_hold: got %b expected 1", sum_valid); end
    checks++; if (sum_out !== 16'sd16384) begin errors++; $display("FAIL multi_out_stall_hold: got %0d expected 16384", sum_out); end
    drive(1'b1, 1'b0, 1'b0, 32'sd0, 16'sd0);
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL multi_pulse_end: got %b expected 0", sum_valid); end
  endtask

  task automatic test_saturation;
    logic signed [31:0] p;
    logic signed [15:0] exp_out;
    for (int k = 0; k < 2; k++) begin
      p       = (k == 0) ? ONE : -ONE;
      exp_out = (k == 0) ? 16'sd32767 : -16'sd32768;
      for (int b = 0; b < 3; b++) drive(1'b1, 1'b1, 1'b0, p, 16'sd0);
      drive(1'b1, 1'b1, 1'b1, p, 16'sd0);
      checks++; if (sum_out !== exp_out) begin errors++; $display("FAIL sat_out[%0d]: got %0d expected %0d", k, sum_out, exp_out); end
      checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag[%0d]: got %b expected 1", k, sat_flag); end
      checks++; if (beat_count !== 9'd4) begin errors++; $display("FAIL sat_count[%0d]: got %0d expected 4", k, beat_count); end
      drive(1'b1, 1'b0, 1'b0, 32'sd0, 16'sd0);
      checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_hold[%0d]: got %b expected 1", k, sat_flag); end
    end
  endtask

  task automatic test_rounding;
    logic signed [31:0] prods [4];
    logic signed [15:0] exps  [4];
    prods[0] = 32'sd8192;  exps[0] = 16'sd1;
    prods[1] = 32'sd8191;  exps[1] = 16'sd0;
    prods[2] = -32'sd8192; exps[2] = 16'sd0;
    prods[3] = -32'sd8193; exps[3] = -16'sd1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, prods[i], 16'sd0);
      checks++; if (sum_out !== exps[i]) begin errors++; $display("FAIL round_out[%0d]: got %0d expected %0d", i, sum_out, exps[i]); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL round_sat[%0d]: got %b expected 0", i, sat_flag); end
    end
  endtask

  task automatic test_stall;
    drive(1'b1, 1'b1, 1'b0, QUARTER, 16'sd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 32'sh7fffffff, 16'sh7fff);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", busy); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b expected 0", sum_valid); end
    // prod_last without prod_valid is not a beat.
    drive(1'b1, 1'b0, 1'b1, 32'sh7fffffff, 16'sh7fff);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_lone_last_busy: got %b expected 1", busy); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL stall_lone_last_valid: got %b expected 0", sum_valid); end
    drive(1'b1, 1'b1, 1'b1, QUARTER, 16'sh7fff);
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL stall_result_valid: got %b expected 1", sum_valid); end
    checks++; if (sum_out !== 16'sd8192) begin errors++; $display("FAIL stall_out: got %0d expected 8192", sum_out); end
    checks++; if (beat_count !== 9'd2) begin errors++; $display("FAIL stall_count: got %0d expected 2", beat_count); end
  endtask

  task automatic test_abort;
    drive(1'b1, 1'b1, 1'b0, ONE, 16'sd0);
    drive(1'b1, 1'b1, 1'b0, ONE, 16'sd0);
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; prod_valid = 1'b1; prod_last = 1'b1; prod = ONE;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", sum_valid); end
    checks++; if (sum_out !== 16'sd0) begin errors++; $display("FAIL abort_out: got %0d expected 0", sum_out); end
    drive(1'b1, 1'b0, 1'b0, 32'sd0, 16'sd0);
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL abort_no_pulse: got %b expected 0", sum_valid); end
    drive(1'b1, 1'b1, 1'b1, ONE, 16'sd0);
    checks++; if (sum_out !== 16'sd16384) begin errors++; $display("FAIL abort_next_out: got %0d expected 16384", sum_out); end
    checks++; if (beat_count !== 9'd1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", beat_count); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL abort_next_sat: got %b expected 0", sat_flag); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b1, 1'b0, QUARTER, 16'sd0);
    drive(1'b1, 1'b1, 1'b1, QUARTER, 16'sd0);
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_a: got %b expected 1", sum_valid); end
    checks++; if (sum_out !== 16'sd8192) begin errors++; $display("FAIL b2b_out_a: got %0d expected 8192", sum_out); end
    checks++; if (beat_count !== 9'd2) begin errors++; $display("FAIL b2b_count_a: got %0d expected 2", beat_count); end
    // New vector opens immediately; its bias must seed a fresh sum (1.0 + 0.25).
    drive(1'b1, 1'b1, 1'b1, ONE, 16'sd4096);
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_b: got %b expected 1", sum_valid); end
    checks++; if (sum_out !== 16'sd20480) begin errors++; $display("FAIL b2b_out_b: got %0d expected 20480", sum_out); end
    checks++; if (beat_count !== 9'd1) begin errors++; $display("FAIL b2b_count_b: got %0d expected 1", beat_count); end
    drive(1'b1, 1'b0, 1'b0, 32'sd0, 16'sd0);
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end: got %b expected 0", sum_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; ce = 1'b0; prod_valid = 1'b0; prod_last = 1'b0;
    prod = '0; bias = '0;
    test_reset();
    test_single();
    test_multi();
    test_saturation();
    test_rounding();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
